apb3_master_fsm: RTL and testbench



---
 rtl/apb_bridge_pkg.sv | 35 +++
 rtl/apb3_master_fsm_timeout.sv | 38 +++
 rtl/apb3_master_fsm.sv | 163 ++++++++++++++++
 tb/tb_apb3_master_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to APB3 bridge: FSM state type and the
// packed command/response word layouts used by both the AXI and APB sides.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } apb_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Command word {write, addr, wdata}; response word {is_write, slverr, rdata}.
  function automatic int cmd_wr_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int rsp_wr_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int rsp_err_bit(input int dw);
    return dw;
  endfunction

  localparam int CMD_W       = 1 + APB_ADDR_W + APB_DATA_W;
  localparam int CMD_WR_BIT  = cmd_wr_bit(APB_ADDR_W, APB_DATA_W);
  localparam int RSP_W       = 2 + APB_DATA_W;
  localparam int RSP_WR_BIT  = rsp_wr_bit(APB_DATA_W);
  localparam int RSP_ERR_BIT = rsp_err_bit(APB_DATA_W);

endpackage

// File: rtl/apb3_master_fsm_timeout.sv
// ACCESS-phase watchdog for apb3_master_fsm; only instantiated when
// APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT-th waiting ACCESS cycle so ACCESS lasts exactly TIMEOUT cycles.
  assign expire_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/apb3_master_fsm.sv
// APB3 requester: pops one command word, runs one SETUP/ACCESS transfer, pushes
// one response word. Optional ACCESS watchdog enabled by APB_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for a command; pops when the FIFO is non-empty
//   LOAD   | FIFO read data valid; latch write/addr/wdata
//   SETUP  | psel=1, penable=0
//   ACCESS | psel=1, penable=1; waits for pready (or watchdog)
//   RESP   | holds the response until the response FIFO accepts it
module apb3_master_fsm
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic [ADDR_W+DATA_W:0]   cmd_rdata,
  input  logic                     cmd_rempty,
  output logic                     cmd_rinc,
  output logic [DATA_W+1:0]        rsp_wdata,
  input  logic                     rsp_wfull,
  output logic                     rsp_winc,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic                     pwrite,
  output logic                     psel,
  output logic                     penable,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     busy,
  output logic [15:0]              err_cnt
);

  localparam int C_WR  = cmd_wr_bit(ADDR_W, DATA_W);
  localparam int R_WR  = rsp_wr_bit(DATA_W);
  localparam int R_ERR = rsp_err_bit(DATA_W);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              tmo_hit;

`ifdef APB_TIMEOUT_EN
  logic acc_wait;
  assign acc_wait = (state_q == ST_ACCESS) && !pready;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (rclk),
    .rst_n_i  (rrst_n),
    .clr_i    (state_q == ST_SETUP),
    .inc_i    (acc_wait),
    .expire_o (tmo_hit)
  );
`else
  // No watchdog in this build: ACCESS waits for pready indefinitely.
  assign tmo_hit = (TIMEOUT < 0) & 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    err_cnt_d   = err_cnt_q;
    cmd_rinc    = 1'b0;
    rsp_winc    = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!cmd_rempty) begin
          cmd_rinc = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pwrite_d = cmd_rdata[C_WR];
        paddr_d  = cmd_rdata[DATA_W +: ADDR_W];
        pwdata_d = cmd_rdata[DATA_W-1:0];
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        psel    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = ST_RESP;
        end else if (tmo_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!rsp_wfull) begin
          rsp_winc = 1'b1;
          state_d  = ST_IDLE;
          if (rsp_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Never pop or push while reset is held; the reset edge discards any in-flight command.
    if (!rrst_n) begin
      cmd_rinc = 1'b0;
      rsp_winc = 1'b0;
    end
  end

  always_comb begin
    rsp_wdata                = '0;
    rsp_wdata[R_WR]          = pwrite_q;
    rsp_wdata[R_ERR]         = rsp_err_q;
    rsp_wdata[DATA_W-1:0]    = rsp_rdata_q;
  end

  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign busy    = (state_q != ST_IDLE);
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb3_master_fsm.sv
// Self-checking bench for apb3_master_fsm: transaction-timeline reference model
// plus directed and randomized traffic. Timeout cases run when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb3_master_fsm;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  typedef logic [AW+DW:0] cmd_t;

  logic             rclk, rrst_n;
  cmd_t             cmd_rdata;
  logic             cmd_rempty, cmd_rinc;
  logic [DW+1:0]    rsp_wdata;
  logic             rsp_wfull, rsp_winc;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata, prdata;
  logic             pwrite, psel, penable, pready, pslverr, busy;
  logic [15:0]      err_cnt;

  apb3_master_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .rclk(rclk), .rrst_n(rrst_n),
    .cmd_rdata(cmd_rdata), .cmd_rempty(cmd_rempty), .cmd_rinc(cmd_rinc),
    .rsp_wdata(rsp_wdata), .rsp_wfull(rsp_wfull), .rsp_winc(rsp_winc),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  cmd_t          mq[$];
  int            cyc = 0;
  bit            in_txn = 0, done = 0, post_rst = 0;
  int            t0 = 0;
  cmd_t          cur;
  logic [DW+1:0] exp_rsp, last_rsp;
  logic [15:0]   err_m = 0;
  int            pop_cnt = 0, push_cnt = 0, last_pop = 0, last_push = 0;
  int            psel_rise = 0, pen_rise = 0, pen_len = 0, resp_start = 0;
  logic          psel_prev = 0, pen_prev = 0;

  always @(negedge rclk) begin : compare
    int d;
    cyc++;
    if (psel && !psel_prev) psel_rise = cyc;
    if (penable) begin
      if (!pen_prev) begin pen_rise = cyc; pen_len = 1; end
      else pen_len++;
    end else if (pen_prev) begin
      resp_start = cyc;
    end
    psel_prev = psel;
    pen_prev  = penable;

    if (!rrst_n) begin
      chk("rinc_in_reset", cmd_rinc, 0);
      chk("winc_in_reset", rsp_winc, 0);
      in_txn = 0; done = 0; err_m = 0; post_rst = 1;
    end else begin
      if (post_rst) begin
        chk("post_reset_ctl", {busy, psel, penable, pwrite}, 0);
        chk("post_reset_paddr", paddr, 0);
        chk("post_reset_pwdata", pwdata, 0);
        chk("post_reset_rsp", rsp_wdata, 0);
        post_rst = 0;
      end
      chk("err_cnt", err_cnt, err_m);
      chk("busy", busy, in_txn);
      if (!in_txn) begin
        chk("rinc_idle", cmd_rinc, !cmd_rempty);
        chk("idle_psel_pen_winc", {psel, penable, rsp_winc}, 0);
        if (!cmd_rempty && mq.size() > 0) begin
          in_txn = 1; done = 0; t0 = cyc;
          cur = mq.pop_front();
          pop_cnt++; last_pop = cyc;
        end
      end else begin
        d = cyc - t0;
        chk("rinc_busy", cmd_rinc, 0);
        if (!done) begin
          chk("psel", psel, d >= 2);
          chk("penable", penable, d >= 3);
          chk("winc_early", rsp_winc, 0);
          if (d >= 2) begin
            chk("paddr", paddr, cur[DW +: AW]);
            chk("pwdata", pwdata, cur[DW-1:0]);
            chk("pwrite", pwrite, cur[AW+DW]);
          end
          if (d >= 3) begin
            if (pready) begin
              done = 1;
              exp_rsp = {cur[AW+DW], pslverr, (cur[AW+DW] ? {DW{1'b0}} : prdata)};
            end
`ifdef APB_TIMEOUT_EN
            else if (d - 3 == TMO - 1) begin
              done = 1;
              exp_rsp = {cur[AW+DW], 1'b1, {DW{1'b0}}};
            end
`endif
          end
        end else begin
          chk("resp_psel_pen", {psel, penable}, 0);
          chk("rsp_wdata", rsp_wdata, exp_rsp);
          chk("rsp_winc", rsp_winc, !rsp_wfull);
          if (!rsp_wfull) begin
            push_cnt++; last_push = cyc; last_rsp = rsp_wdata;
            if (exp_rsp[DW] && err_m != 16'hFFFF) err_m++;
            in_txn = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  cmd_t          fifo_q[$];
  int            fixed_wait = -1, wait_pct = 0, full_pct = 0;
  int            full_hold = 0, full_left = 0, acc_n = 0;
  bit            rand_err = 0, force_err = 0, fix_rd_en = 0;
  logic [DW-1:0] fix_rd = '0;
  logic          pop_s, pen_last = 0, rdy_last = 0;

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dd);
    fifo_q.push_back({w, a, dd});
    mq.push_back({w, a, dd});
    cmd_rempty = 1'b0;
  endtask

  // One clock: sample at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge rclk);
    pop_s = cmd_rinc;
    @(posedge rclk);
    #1;
    if (pop_s && fifo_q.size() > 0) cmd_rdata = fifo_q.pop_front();
    cmd_rempty = (fifo_q.size() == 0);
    if (penable) acc_n++; else acc_n = 0;
    if (fixed_wait >= 0) pready = (acc_n > fixed_wait);
    else pready = ($urandom_range(0, 99) >= wait_pct);
    prdata  = fix_rd_en ? fix_rd : $urandom;
    pslverr = force_err | (rand_err & ($urandom_range(0, 3) == 0));
    if (pen_last && rdy_last && full_hold > 0) full_left = full_hold;
    if (full_left > 0) begin
      rsp_wfull = 1'b1;
      full_left--;
    end else begin
      rsp_wfull = ($urandom_range(0, 99) < full_pct);
    end
    pen_last = penable;
    rdy_last = pready;
  endtask

  task automatic wait_total(input string name, input int target, input int budget);
    for (int i = 0; i < budget && push_cnt < target; i++) step();
    chk(name, push_cnt, target);
  endtask

  initial begin : driver
    int c0, p1, s;
    rrst_n = 1'b0; cmd_rdata = '0; cmd_rempty = 1'b1; rsp_wfull = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) step();
    rrst_n = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rsp", rsp_wdata, 0);

    // zero-wait write
    fixed_wait = 0;
    push_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_total("wr_done", push_cnt + 1, 40);
    chk("wr_psel_lat", psel_rise - last_pop, 2);
    chk("wr_pen_lat", pen_rise - last_pop, 3);
    chk("wr_push_lat", last_push - last_pop, 4);
    chk("wr_rsp", last_rsp, {1'b1, 1'b0, 32'h0});

    // read with three wait states
    fixed_wait = 3; fix_rd_en = 1; fix_rd = 32'h1234_5678;
    push_cmd(1'b0, 32'h0000_0020, 32'h0);
    wait_total("rd_done", push_cnt + 1, 40);
    chk("rd_access_len", pen_len, 4);
    chk("rd_push_lat", last_push - last_pop, 7);
    chk("rd_rsp", last_rsp, {1'b0, 1'b0, 32'h1234_5678});

    // slave error
    fixed_wait = 1; force_err = 1;
    chk("err_before", err_cnt, 0);
    push_cmd(1'b0, 32'h0000_0030, 32'h0);
    wait_total("err_done", push_cnt + 1, 40);
    chk("err_rsp_bit", last_rsp[DW], 1);
    chk("err_cnt_after", err_cnt, 1);
    force_err = 0;

    // response FIFO full for six RESP cycles, second command queued behind
    fixed_wait = 0; full_hold = 6;
    push_cmd(1'b0, 32'h0000_0040, 32'h0);
    push_cmd(1'b1, 32'h0000_0044, 32'h0000_A5A5);
    wait_total("full_done", push_cnt + 1, 60);
    p1 = last_push;
    chk("full_hold_len", last_push - resp_start, 6);
    full_hold = 0;
    wait_total("full_next_done", push_cnt + 1, 40);
    chk("full_next_pop_gap", last_pop - p1, 1);

    // four queued zero-wait commands, back to back
    s = pop_cnt; p1 = push_cnt; c0 = cyc;
    for (int i = 0; i < 4; i++) push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom);
    wait_total("four_done", p1 + 4, 80);
    chk("four_pops", pop_cnt - s, 4);
    chk("four_span", last_push - c0, 20);

    // randomized traffic
    fixed_wait = -1; wait_pct = 35; full_pct = 25; rand_err = 1; fix_rd_en = 0;
    s = push_cnt;
    for (int i = 0; i < 40;) begin
      if ($urandom_range(0, 3) == 0) begin
        push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom);
        i++;
      end
      step();
    end
    wait_total("rand_done", s + 40, 2000);
    wait_pct = 0; full_pct = 0; rand_err = 0;

    // reset during ACCESS
    fixed_wait = 100;
    push_cmd(1'b1, 32'h0000_0050, 32'h0000_1111);
    for (int i = 0; i < 20 && !penable; i++) step();
    chk("reached_access", penable, 1);
    s = push_cnt;
    rrst_n = 1'b0;
    step();
    chk("rst_mid_psel_pen", {psel, penable}, 0);
    chk("rst_mid_busy", busy, 0);
    rrst_n = 1'b1;
    fixed_wait = 0;
    repeat (10) step();
    chk("rst_mid_no_push", push_cnt - s, 0);
    chk("rst_mid_err_cnt", err_cnt, 0);

`ifdef APB_TIMEOUT_EN
    // watchdog expiry with pready held low
    fixed_wait = 100; fix_rd_en = 1; fix_rd = 32'hFFFF_FFFF;
    push_cmd(1'b0, 32'h0000_0060, 32'h0);
    wait_total("tmo_done", push_cnt + 1, 60);
    chk("tmo_access_len", pen_len, TMO);
    chk("tmo_rsp", last_rsp, {1'b0, 1'b1, 32'h0});
    chk("tmo_err_cnt", err_cnt, 1);
    fixed_wait = 0; fix_rd_en = 0;
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
